rom_stream_reader: RTL and testbench

- Sequencer that sits directly upstream of the synchronous-read ROM primitive and also consumes its output.
- On a start command it walks a contiguous address range and drives the ROM's read index.
- It tracks the ROM's 1-cycle read latency, captures returned words, and presents them as a valid/ready stream.
- A small FIFO absorbs backpressure so that no ROM data is lost.

---
 rtl/rom_stream_reader_if.sv | 31 +++
 rtl/rom_stream_reader.sv | 170 +++++++++++++++++
 tb/tb_rom_stream_reader.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rom_stream_reader_if.sv
// rom_stream_reader_if: command, ROM and output-stream signals of rom_stream_reader.
// The master modport is the reader's view. The slave modport is the view of the
// environment, which issues commands, models the ROM and consumes the stream.
interface rom_stream_reader_if #(
  parameter int WIDTH     = 1,
  parameter int ADDR_BITS = 9,
  parameter int CNT_BITS  = ADDR_BITS + 1
);
  logic                 start;
  logic [ADDR_BITS-1:0] base_addr;
  logic [CNT_BITS-1:0]  count;
  logic                 busy;
  logic                 done;
  logic                 rom_rd;
  logic [ADDR_BITS-1:0] rom_idx;
  logic [WIDTH-1:0]     rom_dout;
  logic                 out_valid;
  logic [WIDTH-1:0]     out_data;
  logic                 out_ready;
  logic                 out_last;

  modport master (
    input  start, base_addr, count, rom_dout, out_ready,
    output busy, done, rom_rd, rom_idx, out_valid, out_data, out_last
  );

  modport slave (
    output start, base_addr, count, rom_dout, out_ready,
    input  busy, done, rom_rd, rom_idx, out_valid, out_data, out_last
  );
endinterface

// File: rtl/rom_stream_reader.sv
// rom_stream_reader: walks a contiguous range of a synchronous-read ROM and
// presents the returned words as a valid/ready stream. A 4-entry FIFO absorbs
// backpressure. Reads are throttled so that the FIFO contents plus the reads
// still in flight never exceed 4, which means the FIFO cannot overflow.
// Optional feature: define ROM_STREAM_READER_LAST_EN to carry a per-beat last
// flag through the FIFO. Otherwise out_last is tied low.
module rom_stream_reader #(
  parameter int WIDTH     = 1,
  parameter int ADDR_BITS = 9,
  parameter int CNT_BITS  = ADDR_BITS + 1
) (
  input  logic                clk,
  input  logic                rst,
  rom_stream_reader_if.master bus
);

  localparam int FIFO_DEPTH = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  state_t               state;
  logic                 busy_q;
  logic                 done_q;
  logic                 rom_rd_q;
  logic [ADDR_BITS-1:0] rom_idx_q;
  logic [ADDR_BITS-1:0] addr;
  logic [CNT_BITS-1:0]  rem_issue;
  logic [CNT_BITS-1:0]  rem_ret;

  // Delayed copy of rom_rd: rom_dout carries a requested word this cycle.
  logic                 capture;

  logic [WIDTH-1:0]     fifo_data [FIFO_DEPTH];
`ifdef ROM_STREAM_READER_LAST_EN
  logic                 fifo_last [FIFO_DEPTH];
`endif
  logic [1:0]           wr_ptr;
  logic [1:0]           rd_ptr;
  logic [2:0]           fifo_cnt;

  logic                 accept;
  logic                 push;
  logic                 pop;
  logic [2:0]           occupancy;
  logic                 can_issue;

  // Handshake decode and the read-throttle rule (pops deliberately not credited).
  always_comb begin
    accept    = (state == IDLE) && bus.start;
    push      = capture;
    pop       = (fifo_cnt != 3'd0) && bus.out_ready;
    occupancy = fifo_cnt + 3'(rom_rd_q) + 3'(capture);
    can_issue = (rem_issue != '0) && (occupancy < 3'(FIFO_DEPTH));
  end

  // Command sequencer: owns the state, the read address/strobe, busy and done.
  // The first read is issued on the acceptance edge itself, so rom_rd appears
  // in the cycle right after start.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rom_rd_q  <= 1'b0;
      rom_idx_q <= '0;
      addr      <= '0;
      rem_issue <= '0;
    end else begin
      done_q   <= 1'b0;
      rom_rd_q <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (bus.count == '0) begin
              done_q <= 1'b1;
            end else begin
              state     <= RUN;
              busy_q    <= 1'b1;
              rom_rd_q  <= 1'b1;
              rom_idx_q <= bus.base_addr;
              addr      <= bus.base_addr + ADDR_BITS'(1);
              rem_issue <= bus.count - CNT_BITS'(1);
            end
          end
        end
        RUN: begin
          if (rem_issue == '0) begin
            state <= DRAIN;
          end else if (can_issue) begin
            rom_rd_q  <= 1'b1;
            rom_idx_q <= addr;
            addr      <= addr + ADDR_BITS'(1);
            rem_issue <= rem_issue - CNT_BITS'(1);
            if (rem_issue == CNT_BITS'(1)) begin
              state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (pop && (fifo_cnt == 3'd1) && (rem_ret == '0)) begin
            state  <= IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Return tracking and FIFO bookkeeping: capture qualifier, pointers, fill level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      capture  <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      rem_ret  <= '0;
    end else begin
      capture <= rom_rd_q;
      if (push) begin
        wr_ptr <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 3'd1;
        2'b01:   fifo_cnt <= fifo_cnt - 3'd1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (accept) begin
        rem_ret <= bus.count;
      end else if (push) begin
        rem_ret <= rem_ret - CNT_BITS'(1);
      end
    end
  end

  // FIFO storage. It needs no reset because the read side is gated by fifo_cnt.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= bus.rom_dout;
`ifdef ROM_STREAM_READER_LAST_EN
      fifo_last[wr_ptr] <= (rem_ret == CNT_BITS'(1));
`endif
    end
  end

  // Output drive. The head word is masked while the FIFO is empty, so the
  // stream outputs read 0 out of reset.
  always_comb begin
    bus.busy      = busy_q;
    bus.done      = done_q;
    bus.rom_rd    = rom_rd_q;
    bus.rom_idx   = rom_idx_q;
    bus.out_valid = (fifo_cnt != 3'd0);
    bus.out_data  = bus.out_valid ? fifo_data[rd_ptr] : '0;
`ifdef ROM_STREAM_READER_LAST_EN
    bus.out_last  = bus.out_valid && fifo_last[rd_ptr];
`else
    bus.out_last  = 1'b0;
`endif
  end

endmodule

// File: tb/tb_rom_stream_reader.sv
// tb_rom_stream_reader: table-driven commands, hand-written corner sequences and
// random commands for rom_stream_reader. Expected beats are derived from the
// ROM contents and the command (base, count) with modular arithmetic.
module tb_rom_stream_reader;
  localparam int MW = 8;
  localparam int MA = 5;
  localparam int MC = 6;
  localparam int MD = 1 << MA;
`ifdef ROM_STREAM_READER_LAST_EN
  localparam bit LAST_EN = 1'b1;
`else
  localparam bit LAST_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  rom_stream_reader_if #(.WIDTH(MW), .ADDR_BITS(MA), .CNT_BITS(MC)) m ();
  rom_stream_reader_if #(.WIDTH(1), .ADDR_BITS(2), .CNT_BITS(3)) w ();

  rom_stream_reader #(.WIDTH(MW), .ADDR_BITS(MA), .CNT_BITS(MC)) dut_m (
    .clk(clk), .rst(rst), .bus(m.master));
  rom_stream_reader #(.WIDTH(1), .ADDR_BITS(2), .CNT_BITS(3)) dut_w (
    .clk(clk), .rst(rst), .bus(w.master));

  int unsigned errors = 0;
  int unsigned checks = 0;

  // ROM image: words 0..3 hold 0,0,1,0, the remaining words hold a scrambled pattern.
  function automatic logic [MW-1:0] rom_val(input int unsigned a);
    if (a == 2) return 8'd1;
    if (a < 4) return 8'd0;
    return 8'((a * 37 + 11) & 255);
  endfunction

  function automatic logic exp_last(input int unsigned k, input int unsigned cnt);
    return LAST_EN && (k + 1 == cnt);
  endfunction

  // Synchronous-read ROMs: they read every cycle, whether or not rom_rd is high.
  always @(posedge clk) m.rom_dout <= rom_val(32'(m.rom_idx));
  always @(posedge clk) w.rom_dout <= (w.rom_idx == 2'd2);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one command on the main instance and check everything it produces.
  // Cycle 0 is the cycle in which start is driven.
  task automatic run_cmd(input int unsigned base, input int unsigned cnt,
                         input int unsigned stall, input bit rnd_ready,
                         input bit restart, input int exp_done);
    logic [MW-1:0] expq[$];
    int unsigned rd_seen = 0;
    int unsigned beats = 0;
    int done_cyc = -1;
    int first_rd = -1;
    int first_vld = -1;
    bit hold_pending = 1'b0;
    logic [MW-1:0] held = '0;
    bit finished = 1'b0;
    for (int unsigned i = 0; i < cnt; i++) expq.push_back(rom_val((base + i) % MD));
    m.start = 1'b1;
    m.base_addr = MA'(base);
    m.count = MC'(cnt);
    m.out_ready = 1'b0;
    for (int cyc = 1; cyc <= 300 && !finished; cyc++) begin
      tick();
      if (restart && cyc == 2) begin
        m.start = 1'b1;
        m.base_addr = MA'(base + 9);
        m.count = MC'(cnt + 3);
      end else begin
        m.start = 1'b0;
      end
      m.out_ready = rnd_ready ? ($urandom_range(0, 3) != 0) : (cyc >= int'(stall));
      if (done_cyc >= 0) begin
        chk("done_single_pulse", 64'(m.done), 64'd0);
        chk("idle_after_done", 64'({m.busy, m.rom_rd, m.out_valid}), 64'd0);
        finished = 1'b1;
      end else begin
        if (m.rom_rd) begin
          if (first_rd < 0) first_rd = cyc;
          chk("rom_idx", 64'(m.rom_idx), 64'((base + rd_seen) % MD));
          rd_seen++;
        end
        if (hold_pending) begin
          chk("valid_held", 64'(m.out_valid), 64'd1);
          chk("data_held", 64'(m.out_data), 64'(held));
        end
        if (m.out_valid && first_vld < 0) first_vld = cyc;
        if (m.out_valid && m.out_ready) begin
          if (expq.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL extra_beat: got beat %0d, want at most %0d beats", beats + 1, cnt);
          end else begin
            chk("beat_data", 64'(m.out_data), 64'(expq.pop_front()));
            chk("beat_last", 64'(m.out_last), 64'(exp_last(beats, cnt)));
          end
          beats++;
        end
        hold_pending = m.out_valid && !m.out_ready;
        held = m.out_data;
        if (stall >= 6 && cyc == int'(stall))
          chk("reads_before_ready", 64'(rd_seen), 64'((cnt < 4) ? cnt : 4));
        if (m.done) begin
          done_cyc = cyc;
          chk("beats_at_done", 64'(beats), 64'(cnt));
          chk("reads_at_done", 64'(rd_seen), 64'(cnt));
          if (exp_done >= 0) chk("done_cycle", 64'(done_cyc), 64'(exp_done));
        end
        chk("busy", 64'(m.busy), 64'((cnt != 0) && (done_cyc < 0)));
      end
    end
    if (!finished) begin
      checks++;
      errors++;
      $display("FAIL cmd_timeout: got no done for base=%0d count=%0d, want done", base, cnt);
    end
    if (cnt != 0) begin
      chk("first_rd_cycle", 64'(first_rd), 64'd1);
      chk("first_valid_cycle", 64'(first_vld), 64'd3);
    end
  endtask

  // Small-address instance: one command with out_ready held high.
  task automatic wrap_cmd(input int unsigned wb, input int unsigned wc);
    int unsigned nrd = 0;
    int unsigned nbeat = 0;
    int wdone = -1;
    w.start = 1'b1;
    w.base_addr = 2'(wb);
    w.count = 3'(wc);
    w.out_ready = 1'b1;
    for (int cyc = 1; cyc <= 30 && wdone < 0; cyc++) begin
      tick();
      w.start = 1'b0;
      if (w.rom_rd) begin
        chk("wrap_idx", 64'(w.rom_idx), 64'((wb + nrd) % 4));
        nrd++;
      end
      if (w.out_valid) begin
        chk("wrap_data", 64'(w.out_data), 64'(((wb + nbeat) % 4) == 2));
        nbeat++;
      end
      if (w.done) begin
        wdone = cyc;
        chk("wrap_done_cycle", 64'(cyc), 64'(wc + 3));
        chk("wrap_beats", 64'(nbeat), 64'(wc));
      end
    end
    if (wdone < 0) begin
      checks++;
      errors++;
      $display("FAIL wrap_timeout: got no done for base=%0d count=%0d, want done", wb, wc);
    end
    tick();
  endtask

  typedef struct {
    int unsigned base;
    int unsigned cnt;
    int unsigned stall;
    bit          restart;
    int          exp_done;
  } vec_t;

  vec_t tbl[8];

  initial begin
    tbl[0] = '{base: 0,  cnt: 4,  stall: 0,  restart: 1'b0, exp_done: 7};
    tbl[1] = '{base: 0,  cnt: 0,  stall: 0,  restart: 1'b0, exp_done: 1};
    tbl[2] = '{base: 0,  cnt: 4,  stall: 12, restart: 1'b0, exp_done: 16};
    tbl[3] = '{base: 0,  cnt: 8,  stall: 12, restart: 1'b0, exp_done: 20};
    tbl[4] = '{base: 30, cnt: 5,  stall: 0,  restart: 1'b0, exp_done: 8};
    tbl[5] = '{base: 7,  cnt: 1,  stall: 0,  restart: 1'b0, exp_done: 4};
    tbl[6] = '{base: 0,  cnt: 4,  stall: 0,  restart: 1'b1, exp_done: 7};
    tbl[7] = '{base: 3,  cnt: 20, stall: 0,  restart: 1'b0, exp_done: 23};

    m.start = 1'b0; m.base_addr = '0; m.count = '0; m.out_ready = 1'b0;
    w.start = 1'b0; w.base_addr = '0; w.count = '0; w.out_ready = 1'b0;
    #2 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", 64'({m.busy, m.done, m.rom_rd, m.rom_idx, m.out_valid,
                              m.out_data, m.out_last}), 64'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 8; i++)
      run_cmd(tbl[i].base, tbl[i].cnt, tbl[i].stall, 1'b0, tbl[i].restart, tbl[i].exp_done);

    // Abort after two of four beats have been taken, then run a fresh command.
    m.start = 1'b1; m.base_addr = '0; m.count = MC'(4); m.out_ready = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      tick();
      m.start = 1'b0;
    end
    chk("pre_reset_valid", 64'({m.busy, m.out_valid}), 64'd3);
    rst = 1'b1;
    #1;
    chk("rst_abort_outputs", 64'({m.busy, m.done, m.rom_rd, m.rom_idx, m.out_valid,
                                  m.out_data, m.out_last}), 64'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      tick();
      chk("rst_no_done", 64'({m.done, m.busy, m.out_valid, m.rom_rd}), 64'd0);
    end
    run_cmd(2, 1, 0, 1'b0, 1'b0, 4);

    wrap_cmd(3, 3);
    wrap_cmd(3, 4);

    for (int i = 0; i < 40; i++) begin
      int unsigned rb;
      int unsigned rc;
      int unsigned rs;
      bit rr;
      bit rx;
      rb = $urandom_range(0, MD - 1);
      rc = $urandom_range(0, 12);
      rr = 1'($urandom_range(0, 1));
      rs = rr ? 0 : $urandom_range(0, 10);
      rx = (rc != 0) && ($urandom_range(0, 3) == 0);
      run_cmd(rb, rc, rs, rr, rx, -1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got simulation time limit, want normal completion");
    $fatal(1);
  end

endmodule
